uart_rom_loader: RTL and testbench
==================================

Name: uart_rom_loader

Overview:
Consumes bytes from the UART receiver, parses a framed ROM image and writes 16-bit Hack instruction words into program ROM. While a load is in progress it holds the CPU in reset. On completion it answers ACK or NAK through the UART transmitter. It sits between the UART and the ROM write port / CPU reset in the serial ROM loader SoC.

Parameters:
ADDR_WIDTH, 15, ROM word address width (max image 2**ADDR_WIDTH words)
TIMEOUT_CYCLES, 1000000, max clk cycles between bytes inside a frame before abort

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
received  input  1  one-cycle strobe: rx_byte valid
rx_byte  input  8  byte from UART
recv_error  input  1  UART framing error strobe
is_transmitting  input  1  UART tx busy
transmit  output  1  one-cycle strobe to UART tx
tx_byte  output  8  byte to transmit (ACK/NAK)
rom_we  output  1  one-cycle ROM write strobe
rom_addr  output  ADDR_WIDTH  ROM word address
rom_data  output  16  ROM write data
loading  output  1  high during frame reception and reply; drives CPU reset
done  output  1  sticky: last frame loaded and checksum good
load_error  output  1  sticky: last frame aborted or bad checksum

Behaviour:
- Reset: all outputs 0; state IDLE; checksum, word counter and timeout cleared.
- Frame: SYNC 0xA5, COUNT_HI, COUNT_LO, then COUNT words (hi byte, lo byte), then CHK. CHK = 8-bit mod-256 sum of every byte after SYNC up to the last data byte.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, SEND, WAIT_TX.
- IDLE: bytes other than 0xA5 ignored. On 0xA5: loading=1, done=0, load_error=0, checksum=0, rom_addr=0, then go to CNT_HI.
- CNT_HI/CNT_LO: latch the 16-bit count and add each byte to the checksum. After CNT_LO: count==0 -> CHECK; count > 2**ADDR_WIDTH -> abort; else DATA_HI.
- DATA_HI latches the high byte. On the DATA_LO byte, the next cycle drives rom_we=1 for exactly one cycle with rom_data={hi,lo} and the current rom_addr. rom_addr then increments, and no write ever occurs outside a frame. The last word goes to CHECK, otherwise back to DATA_HI.
- CHECK: received byte == checksum -> reply 0x06 (ACK) and set done. Mismatch -> reply 0x15 (NAK) and set load_error.
- Abort (recv_error, or timeout in any state CNT_HI..CHECK): discard the rest of the frame, set load_error and reply NAK. ROM words already written stay written. Timeout counter reloads on every received strobe and is idle outside those states.
- SEND: wait for is_transmitting==0, then pulse transmit for 1 cycle with tx_byte stable, and go to WAIT_TX.
- WAIT_TX: wait until is_transmitting has been seen 1 and then 0. Drop loading, return to IDLE.
- received strobes in SEND/WAIT_TX are ignored.
- received and recv_error in the same cycle: the error wins.
- rst mid-frame returns to IDLE with all outputs 0. No reply is sent.
- rom_addr width arithmetic: the increment after the last word of a full 2**ADDR_WIDTH image wraps to 0, with no extra write.

Decomposition:
- Shared package uart_rom_loader_pkg: state enum; constants SYNC_BYTE=0xA5, ACK_BYTE=0x06, NAK_BYTE=0x15; header-width constant.
- One sub-module, rom_loader_timeout: down-counter with reload (on received), enable (active states) and an expired strobe, sized by $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Send A5 00 02 12 34 AB CD C0. Required: writes addr0=0x1234 and addr1=0xABCD, one rom_we each; reply 0x06; done=1; loading then drops.
- Same frame with CHK=0xC1. Required: both writes occur; reply 0x15; load_error=1; done=0.
- Send 00 FF 13 then A5 00 00 00. Required: leading bytes ignored; no rom_we; reply 0x06; done=1.
- Send A5 00 03 11 22, then silence for TIMEOUT_CYCLES+1 (TIMEOUT_CYCLES=100 in the bench). Required: one write (0x1122 @0); reply 0x15; load_error=1; return to IDLE.
- Pulse recv_error during DATA_LO. Required: no further rom_we; reply 0x15. Then a subsequent valid frame loads from addr 0 and clears load_error.
- Send COUNT=0x8001 with ADDR_WIDTH=15. Required: abort after CNT_LO; reply 0x15. Separately, rst mid-frame returns all outputs to 0 with no transmit.

Source files
------------

// File: rtl/uart_rom_loader_pkg.sv
// uart_rom_loader_pkg: loader FSM states and the protocol bytes of the ROM image frame
package uart_rom_loader_pkg;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, SEND, WAIT_TX} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam int COUNT_WIDTH = 16;
endpackage

// File: rtl/rom_loader_timeout.sv
// rom_loader_timeout: inter-byte watchdog, reloaded on every received strobe, cleared while disabled
module rom_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_reload) r_cnt <= LOAD;
        else if (!i_enable) r_cnt <= '0;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_expired = i_enable && !i_reload && r_cnt == '0;
endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: parses a framed ROM image from the UART, writes Hack words to ROM, replies ACK/NAK
module uart_rom_loader import uart_rom_loader_pkg::*; #(
    parameter int ADDR_WIDTH = 15,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  recv_error,
    input  logic                  is_transmitting,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  loading,
    output logic                  done,
    output logic                  load_error
);
    state_t r_state, w_next;
    logic [7:0] r_cnt_hi, r_hi, r_chk, r_tx_byte;
    logic [COUNT_WIDTH-1:0] r_left, w_count;
    logic [15:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic r_we, r_transmit, r_loading, r_done, r_err, r_seen;
    logic w_rx, w_active, w_expired, w_abort, w_too_big;

    // a framing error in the same cycle as a byte discards the byte
    assign w_rx = received && !recv_error;
    assign w_active = r_state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
    assign w_abort = w_active && (recv_error || w_expired);
    assign w_count = {r_cnt_hi, rx_byte};
    assign w_too_big = {1'b0, w_count} > (17'd1 << ADDR_WIDTH);

    rom_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .rst(rst),
        .i_reload(received),
        .i_enable(w_active),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_rx && rx_byte == SYNC_BYTE) ? CNT_HI : IDLE;
            CNT_HI:  w_next = w_rx ? CNT_LO : CNT_HI;
            CNT_LO:  w_next = !w_rx ? CNT_LO : w_count == '0 ? CHECK : w_too_big ? SEND : DATA_HI;
            DATA_HI: w_next = w_rx ? DATA_LO : DATA_HI;
            DATA_LO: w_next = !w_rx ? DATA_LO : r_left == COUNT_WIDTH'(1) ? CHECK : DATA_HI;
            CHECK:   w_next = w_rx ? SEND : CHECK;
            SEND:    w_next = is_transmitting ? SEND : WAIT_TX;
            WAIT_TX: w_next = (r_seen && !is_transmitting) ? IDLE : WAIT_TX;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = SEND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt_hi <= '0;
            r_hi <= '0;
            r_chk <= '0;
            r_tx_byte <= '0;
            r_left <= '0;
            r_data <= '0;
            r_addr <= '0;
            r_we <= 1'b0;
            r_transmit <= 1'b0;
            r_loading <= 1'b0;
            r_done <= 1'b0;
            r_err <= 1'b0;
            r_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we <= 1'b0;
            r_transmit <= 1'b0;
            if (r_we) r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_abort) begin
                r_err <= 1'b1;
                r_tx_byte <= NAK_BYTE;
            end else begin
                case (r_state)
                    IDLE: if (w_rx && rx_byte == SYNC_BYTE) begin
                        r_loading <= 1'b1;
                        r_done <= 1'b0;
                        r_err <= 1'b0;
                        r_chk <= '0;
                        r_addr <= '0;
                    end
                    CNT_HI: if (w_rx) begin
                        r_cnt_hi <= rx_byte;
                        r_chk <= r_chk + rx_byte;
                    end
                    CNT_LO: if (w_rx) begin
                        r_left <= w_count;
                        r_chk <= r_chk + rx_byte;
                        if (w_too_big) begin
                            r_err <= 1'b1;
                            r_tx_byte <= NAK_BYTE;
                        end
                    end
                    DATA_HI: if (w_rx) begin
                        r_hi <= rx_byte;
                        r_chk <= r_chk + rx_byte;
                    end
                    DATA_LO: if (w_rx) begin
                        r_data <= {r_hi, rx_byte};
                        r_we <= 1'b1;
                        r_left <= r_left - COUNT_WIDTH'(1);
                        r_chk <= r_chk + rx_byte;
                    end
                    CHECK: if (w_rx) begin
                        r_done <= rx_byte == r_chk;
                        r_err <= rx_byte != r_chk;
                        r_tx_byte <= (rx_byte == r_chk) ? ACK_BYTE : NAK_BYTE;
                    end
                    SEND: begin
                        r_seen <= 1'b0;
                        r_transmit <= !is_transmitting;
                    end
                    WAIT_TX: begin
                        if (is_transmitting) r_seen <= 1'b1;
                        if (r_seen && !is_transmitting) r_loading <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign transmit = r_transmit;
    assign tx_byte = r_tx_byte;
    assign rom_we = r_we;
    assign rom_addr = r_addr;
    assign rom_data = r_data;
    assign loading = r_loading;
    assign done = r_done;
    assign load_error = r_err;
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: table vectors, corner sequences and random frames against a frame-level model
module tb_uart_rom_loader;
    localparam int AW = 15;
    localparam int TO = 100;

    logic clk = 1'b0, rst = 1'b1, received = 1'b0, recv_error = 1'b0, is_transmitting = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic transmit, rom_we, loading, done, load_error;
    logic [7:0] tx_byte;
    logic [AW-1:0] rom_addr;
    logic [15:0] rom_data;

    always #5 clk = ~clk;

    uart_rom_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte), .recv_error(recv_error),
        .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte), .rom_we(rom_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .loading(loading), .done(done), .load_error(load_error)
    );

    int checks = 0, failures = 0, stray = 0, busy = 0, waited = 0, r0 = 0;
    logic [7:0] replies[$];
    logic [AW+15:0] wq[$];
    logic [7:0] q[$];
    logic [7:0] e_rep;
    logic e_dn, e_er;
    logic [15:0] e_w[$];

    // UART transmitter stand-in and ROM write recorder
    always @(negedge clk) begin
        if (rom_we) begin
            wq.push_back({rom_addr, rom_data});
            if (!loading) stray++;
        end
        if (transmit) begin
            replies.push_back(tx_byte);
            busy = 4;
        end else if (busy > 0) busy--;
        is_transmitting = busy != 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b[$], input int gmax);
        foreach (b[i]) begin
            @(negedge clk);
            rx_byte = b[i];
            received = 1'b1;
            repeat ($urandom_range(0, gmax)) begin
                @(negedge clk);
                received = 1'b0;
            end
        end
        @(negedge clk);
        received = 1'b0;
    endtask

    // expected outcome of one frame, derived from the framing rules alone
    function automatic void model(input logic [7:0] b[$]);
        int i = 0;
        int cnt;
        logic [7:0] s;
        while (b[i] != 8'hA5) i++;
        cnt = int'({b[i+1], b[i+2]});
        s = b[i+1] + b[i+2];
        i += 3;
        e_w.delete();
        if (cnt > (1 << AW)) begin
            e_rep = 8'h15;
            e_dn = 1'b0;
            e_er = 1'b1;
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            e_w.push_back({b[i], b[i+1]});
            s += b[i] + b[i+1];
            i += 2;
        end
        e_dn = b[i] == s;
        e_er = !e_dn;
        e_rep = e_dn ? 8'h06 : 8'h15;
    endfunction

    task automatic check_frame(input string nm, input int bound);
        int n = 0;
        while ((replies.size() == r0 || loading) && n < bound) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        chk({nm, " replies"}, 64'(replies.size() - r0), 64'(1));
        if (replies.size() > r0) chk({nm, " reply"}, 64'(replies[r0]), 64'(e_rep));
        chk({nm, " done"}, 64'(done), 64'(e_dn));
        chk({nm, " load_error"}, 64'(load_error), 64'(e_er));
        chk({nm, " loading"}, 64'(loading), 64'(0));
        chk({nm, " nwrites"}, 64'(wq.size()), 64'(e_w.size()));
        foreach (e_w[i])
            if (i < wq.size()) chk($sformatf("%s w%0d", nm, i), 64'(wq[i]), 64'({AW'(i), e_w[i]}));
    endtask

    task automatic start();
        wq.delete();
        r0 = replies.size();
    endtask

    typedef struct {
        int n;
        logic [7:0] b [8];
        logic [7:0] rep;
        logic dn;
        logic er;
        int nw;
        logic [15:0] w [2];
    } vec_t;
    vec_t tv [5];

    initial begin
        tv[0] = '{8, '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 8'h06, 1'b1, 1'b0, 2, '{16'h1234, 16'hABCD}};
        tv[1] = '{8, '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1}, 8'h15, 1'b0, 1'b1, 2, '{16'h1234, 16'hABCD}};
        tv[2] = '{7, '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h06, 1'b1, 1'b0, 0, '{16'h0, 16'h0}};
        tv[3] = '{3, '{8'hA5, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h15, 1'b0, 1'b1, 0, '{16'h0, 16'h0}};
        tv[4] = '{6, '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, 8'h06, 1'b1, 1'b0, 1, '{16'hFFFF, 16'h0}};
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({transmit, tx_byte, rom_we, rom_addr, rom_data, loading, done, load_error}), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            q.delete();
            e_w.delete();
            for (int j = 0; j < tv[k].n; j++) q.push_back(tv[k].b[j]);
            for (int j = 0; j < tv[k].nw; j++) e_w.push_back(tv[k].w[j]);
            e_rep = tv[k].rep;
            e_dn = tv[k].dn;
            e_er = tv[k].er;
            start();
            send(q, 2);
            check_frame($sformatf("vec%0d", k), 400);
            repeat (3) @(negedge clk);
        end
        // silence mid-frame: one word written, then NAK after the watchdog expires
        start();
        q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
        e_w = '{16'h1122};
        e_rep = 8'h15; e_dn = 1'b0; e_er = 1'b1;
        send(q, 0);
        check_frame("timeout", 600);
        chk("timeout latency", 64'(waited >= TO), 64'(1));
        // framing error while waiting for a low data byte
        start();
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        e_w = '{16'h1234};
        send(q, 1);
        @(negedge clk); recv_error = 1'b1;
        @(negedge clk); recv_error = 1'b0;
        check_frame("recv_error", 400);
        start();
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        e_w = '{16'h1234, 16'hABCD};
        e_rep = 8'h06; e_dn = 1'b1; e_er = 1'b0;
        send(q, 1);
        check_frame("reload", 400);
        // error and byte together on the checksum: error must win
        start();
        q = '{8'hA5, 8'h00, 8'h00};
        e_w.delete();
        e_rep = 8'h15; e_dn = 1'b0; e_er = 1'b1;
        send(q, 0);
        @(negedge clk); rx_byte = 8'h00; received = 1'b1; recv_error = 1'b1;
        @(negedge clk); received = 1'b0; recv_error = 1'b0;
        check_frame("error wins", 400);
        // reset mid-frame
        start();
        q = '{8'hA5, 8'h00, 8'h02, 8'h12};
        send(q, 0);
        chk("loading mid-frame", 64'(loading), 64'(1));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst outputs", 64'({transmit, tx_byte, rom_we, rom_addr, rom_data, loading, done, load_error}), 64'(0));
        repeat (30) @(negedge clk);
        chk("rst no reply", 64'(replies.size() - r0), 64'(0));
        chk("rst no write", 64'(wq.size()), 64'(0));
        for (int it = 0; it < 20; it++) begin
            logic [7:0] s;
            int cnt;
            q.delete();
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                q.push_back(g == 8'hA5 ? 8'h00 : g);
            end
            cnt = $urandom_range(0, 5);
            q.push_back(8'hA5);
            q.push_back(8'h00);
            q.push_back(8'(cnt));
            s = 8'(cnt);
            for (int k = 0; k < 2 * cnt; k++) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                q.push_back(d);
                s += d;
            end
            q.push_back(s + 8'($urandom_range(0, 3) == 0));
            model(q);
            start();
            send(q, 3);
            check_frame($sformatf("rand%0d", it), 400);
        end
        chk("no stray writes", 64'(stray), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
